alu_mc: RTL
===========

Name: alu_mc

Overview:
- Multi-cycle, parametrised execute-stage ALU for the CPU datapath. Next generation of the existing single-cycle ALU.
- Keeps the existing op encodings and adds shifts, unsigned compare, iterative multiply and iterative unsigned divide/remainder.
- Operations are accepted and results delivered with valid/ready handshakes on both sides, so the pipeline can stall on long ops.
- Sits between decode/operand-fetch and the memory/writeback stage. Also produces the branch-taken flag and the memory/branch target address.

Parameters:
- WIDTH, 32, datapath width for operands, results and addresses (≥ 8, power of 2).
- OPW, 6, opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any accepted or in-flight op.
- in_valid  in  1  op/operands valid.
- in_ready  out  1  block can accept an op this cycle.
- op  in  OPW  operation code.
- npc  in  WIDTH  next-PC, carried for future relative branches (unused now).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Imm  in  WIDTH  immediate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- alu_o  out  WIDTH  arithmetic result.
- addr_o  out  WIDTH  memory/branch target address.
- ife  out  1  branch taken.
- dz  out  1  divide by zero on DIVU/REMU.

Behaviour:
- Reset: state IDLE; alu_o, addr_o, ife, dz, out_valid all 0; in_ready 1.
- Op codes:
  - 000000 ADD; 000001 SUB; 000010 AND; 000011 OR; 000100 XOR.
  - 000101 SLT signed (result 1 or 0).
  - 000110 SLTU unsigned.
  - 000111 SLL, 001000 SRL, 001001 SRA; shift amount is B[log2(WIDTH)-1:0].
  - 001010 MUL: low WIDTH bits of A*B.
  - 001011 DIVU: quotient; 001100 REMU: remainder.
  - 010000 SW: alu_o=B, addr_o=A+Imm.
  - 010001 LW: addr_o=A+Imm.
  - 100000 BEQ: addr_o=Imm, ife=(A==0).
  - 100010 BNE: addr_o=Imm, ife=(A!=0).
  - 100001 JMP: addr_o=Imm, ife=1.
  - Undefined op: all results 0, completes in 1 cycle.
- Fields not defined by an op are 0. All arithmetic wraps modulo 2^WIDTH.
- FSM states: IDLE, MUL, DIV, DONE.
  - Accept when in_valid && in_ready.
  - Single-cycle op: result registered, go to DONE. out_valid rises the cycle after accept (latency 1).
  - MUL: shift-add, one bit per cycle, WIDTH iterations, then DONE. Latency WIDTH+1.
  - DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations, then DONE. Latency WIDTH+1.
  - Divide by zero: skips iteration. Latency 1, quotient all ones, remainder = A, dz=1.
  - DONE: outputs held stable until out_ready. On out_valid && out_ready, go to IDLE, or to the new op's state if one is accepted the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- While in MUL or DIV, in_ready=0 and operand changes are ignored; operands are latched at accept.
- flush (sync, overrides accept): next state IDLE, out_valid 0, in-flight result discarded. Result registers need not clear.
- Async reset mid-op: immediate IDLE and reset values; no result emitted.
- out_ready high with out_valid low has no effect.

Decomposition:
- Shared package alu_pkg: opcode constants (OP_ADD … OP_JMP, OP_BNE), state enum, WIDTH-derived shift-amount width.
- One natural sub-module, alu_muldiv_iter: shared iterative shift-add/restoring-divide engine with start/done. The top keeps the combinational ops, address, branch logic and FSM.

Test Plan:
- Reset then ADD A=5, B=7 with out_ready=1 -> out_valid on cycle+1, alu_o=12; in_ready stays 1; 4 back-to-back ops produce 4 results on consecutive cycles.
- SLT A=0xFFFFFFFF, B=1 -> alu_o=1. SLTU with the same operands -> 0. SRA A=0x80000000, B=4 -> 0xF8000000.
- MUL A=0x0001_0003, B=0x0000_0005 -> out_valid exactly 33 cycles after accept, alu_o=0x0005_000F; in_ready=0 while busy.
- DIVU A=100, B=7 -> 14; REMU -> 2; DIVU A=9, B=0 -> latency 1, alu_o=0xFFFFFFFF, dz=1.
- Result held with out_ready=0 for 5 cycles -> outputs stable, in_ready=0. BEQ A=0, Imm=0x40 -> ife=1, addr_o=0x40. BNE A=0 -> ife=0.
- Flush at iteration 10 of MUL -> no out_valid, IDLE next cycle. Async rst_n low mid-DIV -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute ALU.
//   - opcode constants (6-bit encodings carried over from the single-cycle ALU)
//   - FSM state encoding
//   - helper giving the shift-amount / iteration-counter width for a datapath width
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;
  localparam logic [5:0] OP_SLTU = 6'b000110;
  localparam logic [5:0] OP_SLL  = 6'b000111;
  localparam logic [5:0] OP_SRL  = 6'b001000;
  localparam logic [5:0] OP_SRA  = 6'b001001;
  localparam logic [5:0] OP_MUL  = 6'b001010;
  localparam logic [5:0] OP_DIVU = 6'b001011;
  localparam logic [5:0] OP_REMU = 6'b001100;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_JMP  = 6'b100001;
  localparam logic [5:0] OP_BNE  = 6'b100010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  // Bits needed to express a shift amount (and an iteration index) for a
  // power-of-two datapath width.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / unsigned-divide engine shared by MUL, DIVU and REMU.
//   One step per clock, WIDTH steps per operation.
//   MUL : shift-add; acc accumulates the low WIDTH bits of a*b.
//   DIV : restoring division; x shifts the dividend out and the quotient in,
//         acc holds the partial remainder.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   flush         abandon the current operation
//   start         load a/b and begin (is_div selects divide)
//   a, b          operands (multiplicand/multiplier or dividend/divisor)
//   done          high in the cycle whose clock edge completes the last step
//   acc_nxt       value acc takes on that edge (product or remainder)
//   quot_nxt      value x takes on that edge (quotient when dividing)
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] quot_nxt
);

  localparam int CW = shamt_w(WIDTH);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic [WIDTH-1:0] x_nxt, y_nxt;
  logic [WIDTH:0]   r_sh, diff;

  always_comb begin
    // Trial subtraction: a borrow in diff[WIDTH] means the shifted remainder
    // is smaller than the divisor, so the old value is restored.
    r_sh = {acc_q, x_q[WIDTH-1]};
    diff = r_sh - {1'b0, y_q};
    if (div_q) begin
      acc_nxt = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      x_nxt   = {x_q[WIDTH-2:0], ~diff[WIDTH]};
      y_nxt   = y_q;
    end else begin
      acc_nxt = acc_q + (y_q[0] ? x_q : '0);
      x_nxt   = x_q << 1;
      y_nxt   = y_q >> 1;
    end
  end

  assign quot_nxt = x_nxt;
  assign done     = busy && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      busy  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // Both operations load the same way: x = a, y = b, acc cleared.
  always_ff @(posedge clk) begin
    if (start) begin
      x_q   <= a;
      y_q   <= b;
      acc_q <= '0;
    end else if (busy) begin
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on input and output.
// Single-cycle ops complete with latency 1; MUL/DIVU/REMU iterate WIDTH cycles
// in alu_muldiv_iter (latency WIDTH+1). Divide by zero bypasses the engine.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous abort of any accepted / in-flight op
//   in_valid, in_ready  input handshake
//   op, npc, A, B, Imm  operation and operands (npc is reserved, unused)
//   out_valid, out_ready output handshake
//   alu_o               arithmetic result
//   addr_o              memory / branch target address
//   ife                 branch taken
//   dz                  divide by zero (DIVU/REMU)
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] Imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_o,
  output logic [WIDTH-1:0] addr_o,
  output logic             ife,
  output logic             dz
);

  localparam int SHW = shamt_w(WIDTH);

  state_t                  state, state_n, op_state;
  logic [5:0]              opc;
  logic                    accept;
  logic                    rem_sel;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        c_alu, c_addr;
  logic                    c_ife, c_dz;
  logic                    eng_done;
  logic [WIDTH-1:0]        eng_acc, eng_quot;
  logic                    unused_npc;

  assign opc        = 6'(op);
  assign a_s        = A;
  assign b_s        = B;
  assign shamt      = B[SHW-1:0];
  assign unused_npc = ^npc;

  // Decode: single-cycle result and the state the op moves the FSM into.
  always_comb begin
    c_alu    = '0;
    c_addr   = '0;
    c_ife    = 1'b0;
    c_dz     = 1'b0;
    op_state = S_DONE;
    case (opc)
      OP_ADD:  c_alu = A + B;
      OP_SUB:  c_alu = A - B;
      OP_AND:  c_alu = A & B;
      OP_OR:   c_alu = A | B;
      OP_XOR:  c_alu = A ^ B;
      OP_SLT:  c_alu = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: c_alu = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  c_alu = A << shamt;
      OP_SRL:  c_alu = A >> shamt;
      OP_SRA:  c_alu = a_s >>> shamt;
      OP_MUL:  op_state = S_MUL;
      OP_DIVU, OP_REMU: begin
        // Zero divisor short-circuits: quotient all ones, remainder = A.
        if (B == '0) begin
          c_dz  = 1'b1;
          c_alu = (opc == OP_DIVU) ? '1 : A;
        end else begin
          op_state = S_DIV;
        end
      end
      OP_SW: begin
        c_alu  = B;
        c_addr = A + Imm;
      end
      OP_LW:  c_addr = A + Imm;
      OP_BEQ: begin
        c_addr = Imm;
        c_ife  = (A == '0);
      end
      OP_BNE: begin
        c_addr = Imm;
        c_ife  = (A != '0);
      end
      OP_JMP: begin
        c_addr = Imm;
        c_ife  = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       if (accept) state_n = op_state;
      S_MUL, S_DIV: if (eng_done) state_n = S_DONE;
      S_DONE:       if (out_ready) state_n = accept ? op_state : S_IDLE;
      default:      state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start    (accept && (op_state != S_DONE)),
    .is_div   (op_state == S_DIV),
    .a        (A),
    .b        (B),
    .done     (eng_done),
    .acc_nxt  (eng_acc),
    .quot_nxt (eng_quot)
  );

  // Result registers: loaded at accept for single-cycle ops, on the final
  // engine step for iterative ones; otherwise held so DONE outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_o   <= '0;
      addr_o  <= '0;
      ife     <= 1'b0;
      dz      <= 1'b0;
      rem_sel <= 1'b0;
    end else if (accept) begin
      alu_o   <= c_alu;
      addr_o  <= c_addr;
      ife     <= c_ife;
      dz      <= c_dz;
      rem_sel <= (opc == OP_REMU);
    end else if (eng_done && !flush) begin
      alu_o  <= ((state == S_DIV) && !rem_sel) ? eng_quot : eng_acc;
      addr_o <= '0;
      ife    <= 1'b0;
      dz     <= 1'b0;
    end
  end

endmodule
